simple_axi_slave_mem: RTL and testbench

AXI4 responder (slave) with on-chip word memory. It is the far end of the team's simple AXI master and serves as its loopback target in block-level benches and on-FPGA bring-up. It uses a 64-bit data bus and 32-bit addresses, and supports INCR bursts. The write and read paths are independent FSMs sharing one memory array.

---
 rtl/simple_axi_pkg.sv | 34 +++
 rtl/simple_axi_slave_ram.sv | 36 +++
 rtl/simple_axi_slave_mem.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_simple_axi_slave_mem.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_axi_pkg.sv
// Shared definitions for the simple AXI4 slave memory.
//   - AXI response and burst encodings
//   - write/read FSM state encodings (2 bits each, exported on o_debug_state)
//   - LFSR seed and taps used by the optional backpressure generator
//   - beat_is_bad(): per-beat protocol/size/burst/range error rule
package simple_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {
        WIdle = 2'b00,
        WData = 2'b01,
        WResp = 2'b10
    } w_state_e;

    typedef enum logic [1:0] {
        RIdle = 2'b00,
        RData = 2'b01
    } r_state_e;

    // Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // A beat fails if the beat is wider than the bus, a non-INCR burst has
    // more than one beat, or the beat address falls outside the memory.
    function automatic logic beat_is_bad(input logic [2:0] size, input logic [1:0] burst,
                                         input logic [7:0] len, input logic in_range);
        return (size > 3'd3) || ((burst != BURST_INCR) && (len != 8'd0)) || !in_range;
    endfunction

endpackage

// File: rtl/simple_axi_slave_ram.sv
// Byte-enabled 64-bit RAM, one write port and one registered read port.
//   clk_i            clock
//   we_i/waddr_i     write enable and word address
//   wdata_i/wstrb_i  write data and byte enables
//   re_i/raddr_i     read enable and word address
//   rdata_o          registered read data, held while re_i is low
// A same-edge read and write to one word returns the old contents.
module simple_axi_slave_ram #(
    parameter int unsigned Depth = 1024,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [63:0]      wdata_i,
    input  logic [7:0]       wstrb_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [63:0]      rdata_o
);

    logic [63:0] mem [Depth];
    logic [63:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 8; b++) begin
                if (wstrb_i[b]) mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
        if (re_i) rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/simple_axi_slave_mem.sv
// AXI4 slave with on-chip 64-bit word memory, INCR bursts, independent
// write and read FSMs sharing one RAM.
//   i_clk, i_rstn        clock, synchronous active-low reset
//   o_debug_state        {write state, read state}
//   s_axi_aw*            write address channel
//   s_axi_w*             write data channel
//   s_axi_b*             write response channel
//   s_axi_ar*            read address channel
//   s_axi_r*             read data channel
// Build option: SIMPLE_AXI_SLAVE_BACKPRESSURE_EN adds LFSR-driven ready
// gating and valid delays for protocol stress testing.
module simple_axi_slave_mem
    import simple_axi_pkg::*;
#(
    parameter int unsigned C_MEM_WORDS = 1024,
    parameter logic [31:0] C_BASE_ADDR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    output logic [3:0]  o_debug_state,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awsize,
    input  logic [1:0]  s_axi_awburst,
    input  logic [7:0]  s_axi_awlen,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    input  logic [63:0] s_axi_wdata,
    input  logic [7:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    output logic [1:0]  s_axi_bresp,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arsize,
    input  logic [1:0]  s_axi_arburst,
    input  logic [7:0]  s_axi_arlen,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [63:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast
);

    localparam int unsigned IDX_W     = $clog2(C_MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(C_MEM_WORDS) << 3;

    // Offset below the base wraps to a huge value, so one compare covers both ends.
    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - C_BASE_ADDR;
        return {1'b0, off} < MEM_BYTES;
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - C_BASE_ADDR;
        return IDX_W'(off >> 3);
    endfunction

    // Backpressure controls; constant zero in the default build.
    logic stall_aw, stall_w, stall_ar, b_hold, r_hold;

    // Write path state
    w_state_e    w_state_q, w_state_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [2:0]  w_size_q, w_size_d;
    logic [1:0]  w_burst_q, w_burst_d;
    logic [7:0]  w_len_q, w_len_d;
    logic [7:0]  w_beat_q, w_beat_d;
    logic        w_err_q, w_err_d;
    logic        w_last_beat, w_beat_bad;

    // Read path state
    r_state_e    r_state_q, r_state_d;
    logic [31:0] r_addr_q;
    logic [2:0]  r_size_q;
    logic [1:0]  r_burst_q;
    logic [7:0]  r_len_q, r_beat_q;
    logic        rlast_q, r_zero_q;
    logic [1:0]  rresp_q;

    // Next read beat to load into the output registers
    logic        r_load, ld_bad;
    logic [31:0] ld_addr;
    logic [2:0]  ld_size;
    logic [1:0]  ld_burst;
    logic [7:0]  ld_len, ld_beat;

    logic        ram_we;
    logic [63:0] ram_rdata;

`ifdef SIMPLE_AXI_SLAVE_BACKPRESSURE_EN
    logic [15:0] lfsr_q;
    logic        b_hold_q, r_hold_q;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            lfsr_q   <= LFSR_SEED;
            b_hold_q <= 1'b0;
            r_hold_q <= 1'b0;
        end else begin
            lfsr_q   <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
            // Hold lasts exactly one cycle after entering the response/beat.
            b_hold_q <= (w_state_q != WResp) && (w_state_d == WResp) && lfsr_q[3];
            r_hold_q <= r_load && lfsr_q[3];
        end
    end

    assign stall_aw = lfsr_q[0];
    assign stall_w  = lfsr_q[1];
    assign stall_ar = lfsr_q[2];
    assign b_hold   = b_hold_q;
    assign r_hold   = r_hold_q;
`else
    assign stall_aw = 1'b0;
    assign stall_w  = 1'b0;
    assign stall_ar = 1'b0;
    assign b_hold   = 1'b0;
    assign r_hold   = 1'b0;
`endif

    // ---------------------------------------------------------------- write
    assign w_last_beat = (w_beat_q == w_len_q);
    assign w_beat_bad  = beat_is_bad(w_size_q, w_burst_q, w_len_q, in_range(w_addr_q)) ||
                         (s_axi_wlast != w_last_beat);

    always_comb begin
        w_state_d     = w_state_q;
        w_addr_d      = w_addr_q;
        w_size_d      = w_size_q;
        w_burst_d     = w_burst_q;
        w_len_d       = w_len_q;
        w_beat_d      = w_beat_q;
        w_err_d       = w_err_q;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        ram_we        = 1'b0;
        unique case (w_state_q)
            WIdle: begin
                s_axi_awready = !stall_aw;
                if (s_axi_awvalid && !stall_aw) begin
                    w_addr_d  = s_axi_awaddr;
                    w_size_d  = s_axi_awsize;
                    w_burst_d = s_axi_awburst;
                    w_len_d   = s_axi_awlen;
                    w_beat_d  = 8'd0;
                    w_err_d   = 1'b0;
                    w_state_d = WData;
                end
            end
            WData: begin
                s_axi_wready = !stall_w;
                if (s_axi_wvalid && !stall_w) begin
                    ram_we   = !w_beat_bad;
                    w_err_d  = w_err_q || w_beat_bad;
                    w_addr_d = w_addr_q + (32'd1 << w_size_q);
                    w_beat_d = w_beat_q + 8'd1;
                    if (s_axi_wlast || w_last_beat) w_state_d = WResp;
                end
            end
            WResp: begin
                s_axi_bvalid = !b_hold;
                if (s_axi_bready && !b_hold) w_state_d = WIdle;
            end
            default: w_state_d = WIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            w_state_q <= WIdle;
            w_addr_q  <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_len_q   <= '0;
            w_beat_q  <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_len_q   <= w_len_d;
            w_beat_q  <= w_beat_d;
            w_err_q   <= w_err_d;
        end
    end

    assign s_axi_bresp = w_err_q ? RESP_SLVERR : RESP_OKAY;

    // ----------------------------------------------------------------- read
    always_comb begin
        r_state_d     = r_state_q;
        r_load        = 1'b0;
        ld_addr       = r_addr_q + (32'd1 << r_size_q);
        ld_size       = r_size_q;
        ld_burst      = r_burst_q;
        ld_len        = r_len_q;
        ld_beat       = r_beat_q + 8'd1;
        s_axi_arready = 1'b0;
        unique case (r_state_q)
            RIdle: begin
                s_axi_arready = !stall_ar;
                if (s_axi_arvalid && !stall_ar) begin
                    r_load    = 1'b1;
                    ld_addr   = s_axi_araddr;
                    ld_size   = s_axi_arsize;
                    ld_burst  = s_axi_arburst;
                    ld_len    = s_axi_arlen;
                    ld_beat   = 8'd0;
                    r_state_d = RData;
                end
            end
            RData: begin
                if (s_axi_rready && !r_hold) begin
                    if (rlast_q) r_state_d = RIdle;
                    else         r_load    = 1'b1;
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    assign ld_bad = beat_is_bad(ld_size, ld_burst, ld_len, in_range(ld_addr));

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state_q <= RIdle;
            r_addr_q  <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            r_zero_q  <= 1'b1;
        end else begin
            r_state_q <= r_state_d;
            if (r_load) begin
                r_addr_q  <= ld_addr;
                r_size_q  <= ld_size;
                r_burst_q <= ld_burst;
                r_len_q   <= ld_len;
                r_beat_q  <= ld_beat;
                rlast_q   <= (ld_beat == ld_len);
                rresp_q   <= ld_bad ? RESP_SLVERR : RESP_OKAY;
                r_zero_q  <= ld_bad;
            end else if (r_state_d == RIdle) begin
                rlast_q  <= 1'b0;
                rresp_q  <= RESP_OKAY;
                r_zero_q <= 1'b1;
            end
        end
    end

    // RAM output register is not reset; r_zero_q masks it until a good beat loads.
    assign s_axi_rvalid  = (r_state_q == RData) && !r_hold;
    assign s_axi_rdata   = r_zero_q ? 64'd0 : ram_rdata;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;
    assign o_debug_state = {w_state_q, r_state_q};

    simple_axi_slave_ram #(
        .Depth (C_MEM_WORDS)
    ) u_ram (
        .clk_i   (i_clk),
        .we_i    (ram_we),
        .waddr_i (word_index(w_addr_q)),
        .wdata_i (s_axi_wdata),
        .wstrb_i (s_axi_wstrb),
        .re_i    (r_load),
        .raddr_i (word_index(ld_addr)),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_simple_axi_slave_mem.sv
// Bench for simple_axi_slave_mem: reset checks, a vector table of single-beat
// transfers, hand-written multi-cycle sequences and randomized bursts checked
// against a word-array reference model.
module tb_simple_axi_slave_mem;

    localparam int unsigned WORDS = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          GUARD = 200;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  debug_state;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] awaddr, araddr;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [7:0]  awlen, arlen, wstrb;
    logic [63:0] wdata, rdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] mdl      [WORDS];
    logic [63:0] wbuf     [256];
    logic [7:0]  sbuf     [256];
    logic [63:0] exp_data [256];
    logic [1:0]  exp_resp [256];

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [1:0]  resp;
        logic [63:0] rdata;
    } vec_t;

    vec_t vecs [14];

    always #5 clk = ~clk;

    simple_axi_slave_mem #(
        .C_MEM_WORDS (WORDS),
        .C_BASE_ADDR (BASE)
    ) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .o_debug_state (debug_state),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_awaddr  (awaddr),
        .s_axi_awsize  (awsize),
        .s_axi_awburst (awburst),
        .s_axi_awlen   (awlen),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wlast   (wlast),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_bresp   (bresp),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_araddr  (araddr),
        .s_axi_arsize  (arsize),
        .s_axi_arburst (arburst),
        .s_axi_arlen   (arlen),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rlast   (rlast)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: no handshake within %0d cycles, expected one", name, GUARD);
    endtask

    // Reference model: plain per-beat address arithmetic over a word array.
    function automatic bit model_bad(longint a, int size, int burst, int len);
        return size > 3 || (burst != 1 && len > 0) || a < longint'(BASE) ||
               a >= longint'(BASE) + 8 * longint'(WORDS);
    endfunction

    function automatic logic [1:0] model_write(longint addr, int size, int burst, int len,
                                               int wlast_beat);
        bit err = 0;
        for (int i = 0; i <= len; i++) begin
            longint a;
            bit     bad;
            a   = addr + longint'(i) * (longint'(1) << size);
            bad = model_bad(a, size, burst, len) || ((i == wlast_beat) != (i == len));
            if (bad) err = 1;
            else begin
                for (int b = 0; b < 8; b++)
                    if (sbuf[i][b]) mdl[int'((a - longint'(BASE)) / 8)][b*8 +: 8] = wbuf[i][b*8 +: 8];
            end
            if (i == wlast_beat) break;
        end
        return err ? 2'b10 : 2'b00;
    endfunction

    function automatic void model_read(longint addr, int size, int burst, int len);
        for (int i = 0; i <= len; i++) begin
            longint a;
            a = addr + longint'(i) * (longint'(1) << size);
            if (model_bad(a, size, burst, len)) begin
                exp_data[i] = 64'd0;
                exp_resp[i] = 2'b10;
            end else begin
                exp_data[i] = mdl[int'((a - longint'(BASE)) / 8)];
                exp_resp[i] = 2'b00;
            end
        end
    endfunction

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic axi_write(input logic [31:0] addr, input logic [2:0] size,
                             input logic [1:0] burst, input logic [7:0] len,
                             input int wlast_beat, input bit rnd, output logic [1:0] resp);
        bit hs;
        int g;
        resp    = 2'bxx;
        awaddr  = addr;
        awsize  = size;
        awburst = burst;
        awlen   = len;
        awvalid = 1'b1;
        hs = 0; g = 0;
        while (!hs && g < GUARD) begin
            @(negedge clk); hs = awready;
            @(posedge clk); #1; g++;
        end
        awvalid = 1'b0;
        if (!hs) begin timeout("aw handshake"); return; end
        for (int i = 0; i < 256; i++) begin
            if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            wvalid = 1'b1;
            wdata  = wbuf[i];
            wstrb  = sbuf[i];
            wlast  = (i == wlast_beat);
            hs = 0; g = 0;
            while (!hs && g < GUARD) begin
                @(negedge clk); hs = wready;
                @(posedge clk); #1; g++;
            end
            wvalid = 1'b0;
            wlast  = 1'b0;
            if (!hs) begin timeout("w handshake"); return; end
            if (i == int'(len) || i == wlast_beat) break;
        end
        if (rnd) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        bready = 1'b1;
        hs = 0; g = 0;
        while (!hs && g < GUARD) begin
            @(negedge clk); hs = bvalid;
            if (hs) resp = bresp;
            @(posedge clk); #1; g++;
        end
        bready = 1'b0;
        if (!hs) timeout("b handshake");
    endtask

    // Compares every cycle with rvalid high (stalled ones too) against exp_*.
    task automatic axi_read(input logic [31:0] addr, input logic [2:0] size,
                            input logic [1:0] burst, input logic [7:0] len,
                            input int stall_beat, input int stall_cycles, input bit rnd,
                            input string tag);
        bit hs;
        int g, beat, stalled;
        araddr  = addr;
        arsize  = size;
        arburst = burst;
        arlen   = len;
        arvalid = 1'b1;
        hs = 0; g = 0;
        while (!hs && g < GUARD) begin
            @(negedge clk); hs = arready;
            @(posedge clk); #1; g++;
        end
        arvalid = 1'b0;
        if (!hs) begin timeout({tag, " ar handshake"}); return; end
        beat = 0; g = 0; stalled = 0;
        while (beat <= int'(len) && g < GUARD * 4) begin
            if (beat == stall_beat && stalled < stall_cycles) rready = 1'b0;
            else if (rnd) rready = ($urandom_range(0, 3) != 0);
            else rready = 1'b1;
            @(negedge clk);
            if (rvalid) begin
                check($sformatf("%s rdata b%0d", tag, beat), rdata, exp_data[beat]);
                check($sformatf("%s rresp b%0d", tag, beat), 64'(rresp), 64'(exp_resp[beat]));
                check($sformatf("%s rlast b%0d", tag, beat), 64'(rlast), 64'(beat == int'(len)));
                if (rready) beat++;
                else if (beat == stall_beat) stalled++;
            end
            @(posedge clk); #1; g++;
        end
        rready = 1'b0;
        if (beat <= int'(len)) timeout({tag, " r beats"});
        @(negedge clk);
        check({tag, " rvalid low after burst"}, 64'(rvalid), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1);
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] ra;
        logic [2:0]  rs;
        logic [1:0]  rb;
        logic [7:0]  rl;
        int          wl, g;
        bit          hs;

        rstn = 1'b0;
        {awvalid, wvalid, wlast, bready, arvalid, rready} = '0;
        awaddr = '0; awsize = '0; awburst = '0; awlen = '0; wdata = '0; wstrb = '0;
        araddr = '0; arsize = '0; arburst = '0; arlen = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset awready", 64'(awready), 64'd1);
        check("reset arready", 64'(arready), 64'd1);
        check("reset wready", 64'(wready), 64'd0);
        check("reset bvalid", 64'(bvalid), 64'd0);
        check("reset rvalid", 64'(rvalid), 64'd0);
        check("reset rlast", 64'(rlast), 64'd0);
        check("reset bresp", 64'(bresp), 64'd0);
        check("reset rresp", 64'(rresp), 64'd0);
        check("reset rdata", rdata, 64'd0);
        check("reset debug_state", 64'(debug_state), 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Fill all of memory so every later read has a known expectation.
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 256; i++) begin
                wbuf[i] = {32'(blk * 256 + i), 32'h5A5A_0000 ^ 32'(blk * 256 + i)};
                sbuf[i] = 8'hFF;
            end
            void'(model_write(blk * 2048, 3, 1, 255, 255));
            axi_write(32'(blk * 2048), 3'd3, 2'b01, 8'd255, 255, 1'b0, resp);
            check($sformatf("fill%0d bresp", blk), 64'(resp), 64'd0);
        end

        // is_wr, addr, size, burst, data, strb, resp, rdata
        vecs[0]  = '{1, 32'h10,   3'd3, 2'b01, 64'h1122_3344_5566_7788, 8'hFF, 2'b00, 64'h0};
        vecs[1]  = '{0, 32'h10,   3'd3, 2'b01, 64'h0, 8'h00, 2'b00, 64'h1122_3344_5566_7788};
        vecs[2]  = '{1, 32'h10,   3'd3, 2'b01, 64'hFFFF_FFFF_AAAA_BBBB, 8'h0F, 2'b00, 64'h0};
        vecs[3]  = '{0, 32'h10,   3'd3, 2'b01, 64'h0, 8'h00, 2'b00, 64'h1122_3344_AAAA_BBBB};
        vecs[4]  = '{1, 32'h10,   3'd4, 2'b01, 64'h0, 8'hFF, 2'b10, 64'h0};
        vecs[5]  = '{0, 32'h10,   3'd3, 2'b01, 64'h0, 8'h00, 2'b00, 64'h1122_3344_AAAA_BBBB};
        vecs[6]  = '{1, 32'h1FF8, 3'd3, 2'b01, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 2'b00, 64'h0};
        vecs[7]  = '{0, 32'h1FF8, 3'd3, 2'b01, 64'h0, 8'h00, 2'b00, 64'hDEAD_BEEF_CAFE_F00D};
        vecs[8]  = '{1, 32'h2000, 3'd3, 2'b01, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b10, 64'h0};
        vecs[9]  = '{0, 32'h2000, 3'd3, 2'b01, 64'h0, 8'h00, 2'b10, 64'h0};
        vecs[10] = '{1, 32'h24,   3'd3, 2'b00, 64'h0BAD_F00D_1234_5678, 8'hF0, 2'b00, 64'h0};
        vecs[11] = '{0, 32'h20,   3'd3, 2'b01, 64'h0, 8'h00, 2'b00, 64'h0BAD_F00D_5A5A_0004};
        vecs[12] = '{0, 32'h10,   3'd4, 2'b01, 64'h0, 8'h00, 2'b10, 64'h0};
        vecs[13] = '{0, 32'h18,   3'd3, 2'b10, 64'h0, 8'h00, 2'b00, 64'h0000_0003_5A5A_0003};

        foreach (vecs[k]) begin
            if (vecs[k].is_wr) begin
                wbuf[0] = vecs[k].data;
                sbuf[0] = vecs[k].strb;
                void'(model_write(vecs[k].addr, vecs[k].size, vecs[k].burst, 0, 0));
                axi_write(vecs[k].addr, vecs[k].size, vecs[k].burst, 8'd0, 0, 1'b0, resp);
                check($sformatf("vec%0d bresp", k), 64'(resp), 64'(vecs[k].resp));
            end else begin
                exp_data[0] = vecs[k].rdata;
                exp_resp[0] = vecs[k].resp;
                axi_read(vecs[k].addr, vecs[k].size, vecs[k].burst, 8'd0, -1, 0, 1'b0,
                         $sformatf("vec%0d", k));
            end
        end

        // INCR burst of four, read back with a two-cycle stall on beat 1.
        for (int i = 0; i < 4; i++) begin wbuf[i] = 64'(i + 1); sbuf[i] = 8'hFF; end
        void'(model_write(32'h100, 3, 1, 3, 3));
        axi_write(32'h100, 3'd3, 2'b01, 8'd3, 3, 1'b0, resp);
        check("burst4 bresp", 64'(resp), 64'd0);
        for (int i = 0; i < 4; i++) begin exp_data[i] = 64'(i + 1); exp_resp[i] = 2'b00; end
        axi_read(32'h100, 3'd3, 2'b01, 8'd3, 1, 2, 1'b0, "burst4 stall");

        // Read across the top of memory: only the second beat fails.
        exp_data[0] = 64'hDEAD_BEEF_CAFE_F00D; exp_resp[0] = 2'b00;
        exp_data[1] = 64'd0;                   exp_resp[1] = 2'b10;
        axi_read(32'h1FF8, 3'd3, 2'b01, 8'd1, -1, 0, 1'b0, "top cross");

        // Early wlast on beat 1 of a three-beat burst.
        for (int i = 0; i < 3; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
        void'(model_write(32'h200, 3, 1, 2, 1));
        axi_write(32'h200, 3'd3, 2'b01, 8'd2, 1, 1'b0, resp);
        check("early wlast bresp", 64'(resp), 64'h2);
        model_read(32'h200, 3, 1, 2);
        axi_read(32'h200, 3'd3, 2'b01, 8'd2, -1, 0, 1'b0, "early wlast rd");

        // Reset pulse while a read burst is presenting data.
        araddr = 32'h100; arsize = 3'd3; arburst = 2'b01; arlen = 8'd3; arvalid = 1'b1;
        rready = 1'b0;
        hs = 0; g = 0;
        while (!hs && g < GUARD) begin
            @(negedge clk); hs = arready;
            @(posedge clk); #1; g++;
        end
        arvalid = 1'b0;
        if (!hs) timeout("rst ar handshake");
        @(negedge clk);
        check("rst pre rvalid", 64'(rvalid), 64'd1);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        check("rst rvalid", 64'(rvalid), 64'd0);
        check("rst arready", 64'(arready), 64'd1);
        check("rst debug_state", 64'(debug_state), 64'd0);
        for (int i = 0; i < 4; i++) begin exp_data[i] = 64'(i + 1); exp_resp[i] = 2'b00; end
        axi_read(32'h100, 3'd3, 2'b01, 8'd3, -1, 0, 1'b0, "post rst");

        // Randomized bursts with random handshake timing.
        for (int t = 0; t < 30; t++) begin
            ra = $urandom_range(0, 32'h2080);
            if ($urandom_range(0, 3) != 0) ra[2:0] = 3'd0;
            rs = ($urandom_range(0, 9) < 8) ? 3'd3 : 3'($urandom_range(0, 4));
            rb = ($urandom_range(0, 9) < 8) ? 2'b01 : 2'($urandom_range(0, 2));
            rl = 8'($urandom_range(0, 7));
            wl = ($urandom_range(0, 9) < 8) ? int'(rl) : $urandom_range(0, int'(rl) + 1);
            for (int i = 0; i < 9; i++) begin
                wbuf[i] = {$urandom, $urandom};
                sbuf[i] = 8'($urandom);
            end
            axi_write(ra, rs, rb, rl, wl, 1'b1, resp);
            check($sformatf("rand%0d bresp", t), 64'(resp), 64'(model_write(ra, rs, rb, rl, wl)));

            ra = $urandom_range(0, 32'h2080);
            rs = ($urandom_range(0, 9) < 8) ? 3'd3 : 3'($urandom_range(0, 4));
            rb = ($urandom_range(0, 9) < 8) ? 2'b01 : 2'($urandom_range(0, 2));
            rl = 8'($urandom_range(0, 7));
            model_read(ra, rs, rb, rl);
            axi_read(ra, rs, rb, rl, -1, 0, 1'b1, $sformatf("rand%0d rd", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
